// File: rtl/decode_event_monitor.sv
// Instruction-decode event monitor.
// Watches fetched instruction words on the Wishbone return path and classifies each one as
// ebreak, jal, jalr, mret or ecall. Each class has a saturating counter and a registered
// pulse. Events are queued in a small FIFO with a valid/ready drain port. A sticky flag
// records any event dropped because the FIFO was full.
//
// Ports:
//   wb_clk, wb_rst_n : clock and asynchronous active-low reset
//   wb_rdt, wb_en    : instruction bits [31:2] and their qualifier
//   i_clr            : synchronous clear of counters, overflow flag and FIFO
//   o_ebreak         : one-cycle pulse per ebreak event
//   o_jal_or_jalr    : one-cycle pulse per jal or jalr event
//   o_mret           : one-cycle pulse per mret event
//   o_cnt            : per-class counters; class k is at [k*CNT_W +: CNT_W]
//   o_ev_valid       : FIFO holds at least one entry
//   o_ev_data        : head entry {class[2:0], instr[31:2]}; zero when the FIFO is empty
//   i_ev_ready       : pop the head entry when o_ev_valid is high
//   o_ev_level       : FIFO occupancy
//   o_ovf            : sticky overflow flag
module decode_event_monitor #(
    parameter bit          PRE_REGISTER = 1'b1,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEPTH        = 4,
    parameter logic [4:0]  EV_MASK      = 5'b11111
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic [31:2]              wb_rdt,
    input  logic                     wb_en,
    input  logic                     i_clr,
    output logic                     o_ebreak,
    output logic                     o_jal_or_jalr,
    output logic                     o_mret,
    output logic [5*CNT_W-1:0]       o_cnt,
    output logic                     o_ev_valid,
    output logic [32:0]              o_ev_data,
    input  logic                     i_ev_ready,
    output logic [$clog2(DEPTH):0]   o_ev_level,
    output logic                     o_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    // Word being classified this cycle.
    logic        dec_vld;
    logic [31:2] dec_word;

    if (PRE_REGISTER) begin : g_pre
        logic        vld_q;
        logic [31:2] word_q;

        always_ff @(posedge wb_clk or negedge wb_rst_n) begin
            if (!wb_rst_n) begin
                vld_q  <= 1'b0;
                word_q <= '0;
            end else begin
                // Not affected by i_clr: an event in this stage completes after the clear.
                vld_q <= wb_en;
                if (wb_en) begin
                    word_q <= wb_rdt;
                end
            end
        end

        assign dec_vld  = vld_q;
        assign dec_word = word_q;
    end else begin : g_direct
        assign dec_vld  = wb_en;
        assign dec_word = wb_rdt;
    end

    // Class patterns are mutually exclusive, so hit is one-hot or zero.
    logic [4:0] match;
    logic [4:0] hit;
    logic [2:0] ev_class;
    logic       ev;

    always_comb begin
        match    = '0;
        match[0] = (dec_word == 30'h0004001C);
        match[1] = (dec_word[6:2] == 5'b11011);
        match[2] = (dec_word[6:2] == 5'b11001) && (dec_word[14:12] == 3'b000);
        match[3] = (dec_word == 30'h0C08001C);
        match[4] = (dec_word == 30'h0000001C);
    end

    assign hit = match & EV_MASK & {5{dec_vld}};
    assign ev  = |hit;

    always_comb begin
        ev_class = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (hit[k]) begin
                ev_class = 3'(k);
            end
        end
    end

    // Counters and pulses.
    logic [CNT_W-1:0] cnt_q [5];
    logic [2:0]       pulse_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int k = 0; k < 5; k++) begin
                cnt_q[k] <= '0;
            end
            pulse_q <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < 5; k++) begin
                cnt_q[k] <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (hit[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
            pulse_q <= {hit[3], hit[1] | hit[2], hit[0]};
        end
    end

    assign o_ebreak      = pulse_q[0];
    assign o_jal_or_jalr = pulse_q[1];
    assign o_mret        = pulse_q[2];

    always_comb begin
        o_cnt = '0;
        for (int k = 0; k < 5; k++) begin
            o_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    // Event FIFO.
    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && i_ev_ready;
    // A pop frees the slot the same-cycle push needs when full.
    assign push  = ev && (!full || pop);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (i_clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            level_q <= level_q + LW'(push) - LW'(pop);
            if (ev && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge wb_clk) begin
        if (push && !i_clr) begin
            mem_q[wptr_q] <= {ev_class, dec_word};
        end
    end

    assign o_ev_valid = !empty;
    assign o_ev_data  = empty ? '0 : mem_q[rptr_q];
    assign o_ev_level = level_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_decode_event_monitor.sv
// Bench for decode_event_monitor. Two instances share one stimulus stream:
//   u0: pre-registered, 16-bit counters, 4-deep FIFO, all classes enabled
//   u1: direct decode, 4-bit counters, 2-deep FIFO, ebreak disabled
// A cycle-level reference model predicts pulses, counters and overflow, and keeps each
// FIFO's expected contents in a queue; the monitor pops that queue whenever the DUT drains.
module tb_decode_event_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:2] wb_rdt = '0;
    logic        wb_en = 1'b0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;

    logic        eb0, jj0, mr0, v0, ovf0;
    logic [79:0] cnt0;
    logic [32:0] d0;
    logic [2:0]  lv0;
    logic        eb1, jj1, mr1, v1, ovf1;
    logic [19:0] cnt1;
    logic [32:0] d1;
    logic [1:0]  lv1;

    always #5 clk = ~clk;

    decode_event_monitor #(
        .PRE_REGISTER(1'b1), .CNT_W(16), .DEPTH(4), .EV_MASK(5'b11111)
    ) u0 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_rdt(wb_rdt), .wb_en(wb_en), .i_clr(clr),
        .o_ebreak(eb0), .o_jal_or_jalr(jj0), .o_mret(mr0), .o_cnt(cnt0),
        .o_ev_valid(v0), .o_ev_data(d0), .i_ev_ready(ready), .o_ev_level(lv0), .o_ovf(ovf0)
    );

    decode_event_monitor #(
        .PRE_REGISTER(1'b0), .CNT_W(4), .DEPTH(2), .EV_MASK(5'b11110)
    ) u1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_rdt(wb_rdt), .wb_en(wb_en), .i_clr(clr),
        .o_ebreak(eb1), .o_jal_or_jalr(jj1), .o_mret(mr1), .o_cnt(cnt1),
        .o_ev_valid(v1), .o_ev_data(d1), .i_ev_ready(ready), .o_ev_level(lv1), .o_ovf(ovf1)
    );

    localparam logic [31:2] W_EBREAK = 30'h0004001C;
    localparam logic [31:2] W_ECALL  = 30'h0000001C;
    localparam logic [31:2] W_MRET   = 30'h0C08001C;
    localparam logic [31:2] W_JAL    = 30'h0000001B;
    localparam logic [31:2] W_JALR   = 30'h00002019;
    localparam logic [31:2] W_ADDI   = 30'h00040024;

    // Per-instance configuration as seen by the model.
    int         m_pre   [2] = '{1, 0};
    int         m_cntw  [2] = '{16, 4};
    int         m_depth [2] = '{4, 2};
    logic [4:0] m_mask  [2] = '{5'b11111, 5'b11110};

    // Model state.
    int          m_cnt    [2][5];
    bit          m_ovf    [2];
    bit          m_pend_v [2];
    logic [31:2] m_pend_w [2];
    bit   [2:0]  m_pulse  [2];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    int checks = 0;
    int failures = 0;

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [32:0] qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int k, input logic [32:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    // Class of an instruction word, or -1 when none applies or the class is disabled.
    function automatic int classify(input logic [31:2] w, input logic [4:0] mask);
        int c;
        c = -1;
        if (w == 30'h0004001C) c = 0;
        else if (w[6:2] == 5'b11011) c = 1;
        else if (w[6:2] == 5'b11001 && w[14:12] == 3'b000) c = 2;
        else if (w == 30'h0C08001C) c = 3;
        else if (w == 30'h0000001C) c = 4;
        if (c >= 0 && !mask[c]) c = -1;
        return c;
    endfunction

    task automatic model_reset(input int k);
        for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
        m_ovf[k]    = 0;
        m_pend_v[k] = 0;
        m_pend_w[k] = '0;
        m_pulse[k]  = '0;
        qclear(k);
    endtask

    // One clock edge. The monitor has already removed any entry drained at this edge,
    // so a push fits exactly when the queue is below depth.
    task automatic model_step(input int k);
        bit          ev_v;
        logic [31:2] ev_w;
        int          c;
        if (m_pre[k] != 0) begin
            ev_v = m_pend_v[k];
            ev_w = m_pend_w[k];
            m_pend_v[k] = wb_en;
            if (wb_en) m_pend_w[k] = wb_rdt;
        end else begin
            ev_v = wb_en;
            ev_w = wb_rdt;
        end
        m_pulse[k] = '0;
        c = ev_v ? classify(ev_w, m_mask[k]) : -1;
        if (clr) begin
            for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
            m_ovf[k] = 0;
            qclear(k);
        end else if (c >= 0) begin
            if (m_cnt[k][c] < (1 << m_cntw[k]) - 1) m_cnt[k][c] = m_cnt[k][c] + 1;
            if (c == 0) m_pulse[k][0] = 1'b1;
            if (c == 1 || c == 2) m_pulse[k][1] = 1'b1;
            if (c == 3) m_pulse[k][2] = 1'b1;
            if (qsize(k) < m_depth[k]) qpush(k, {c[2:0], ev_w});
            else m_ovf[k] = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else model_step(k);
        end
    end

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic monitor(input int k);
        logic [2:0]  pl;
        logic        vld;
        logic [32:0] dat;
        int          lvl;
        logic        ovf;
        int          c [5];
        if (k == 0) begin
            pl = {mr0, jj0, eb0}; vld = v0; dat = d0; lvl = int'(lv0); ovf = ovf0;
            for (int i = 0; i < 5; i++) c[i] = int'(cnt0[i*16 +: 16]);
        end else begin
            pl = {mr1, jj1, eb1}; vld = v1; dat = d1; lvl = int'(lv1); ovf = ovf1;
            for (int i = 0; i < 5; i++) c[i] = int'(cnt1[i*4 +: 4]);
        end
        chk("pulses", k, 64'(pl), 64'(m_pulse[k]));
        chk("ev_valid", k, 64'(vld), 64'(qsize(k) > 0));
        chk("ev_level", k, 64'(lvl), 64'(qsize(k)));
        chk("ovf", k, 64'(ovf), 64'(m_ovf[k]));
        for (int i = 0; i < 5; i++) chk($sformatf("cnt%0d", i), k, 64'(c[i]), 64'(m_cnt[k][i]));
        if (!rst_n) begin
            chk("ev_data_reset", k, 64'(dat), 64'd0);
        end else if (qsize(k) > 0) begin
            chk("ev_data_head", k, 64'(dat), 64'(qfront(k)));
            if (ready) qpop(k);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) monitor(k);
    end

    task automatic step(input logic en, input logic [31:2] w, input logic rdy, input logic c);
        wb_en  = en;
        wb_rdt = w;
        ready  = rdy;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 30'($urandom), rdy, 1'b0);
    endtask

    function automatic logic [31:2] rand_word();
        logic [31:2] w;
        w = 30'($urandom);
        case ($urandom_range(0, 7))
            0: w = W_EBREAK;
            1: w = W_ECALL;
            2: w = W_MRET;
            3: w[6:2] = 5'b11011;
            4: w[6:2] = 5'b11001;
            5: w = W_JALR;
            6: w = W_ADDI;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single ebreak, then drain it.
        step(1'b1, W_EBREAK, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(2, 1'b1);

        // jal and jalr back to back, then drain.
        step(1'b1, W_JAL, 1'b0, 1'b0);
        step(1'b1, W_JALR, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Overfill with mrets, then pop while pushing at full.
        for (int i = 0; i < 6; i++) step(1'b1, W_MRET, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, W_JAL, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Non-matching word.
        step(1'b1, W_ADDI, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Saturate the narrow counters, then clear with an ecall in flight.
        for (int i = 0; i < 17; i++) step(1'b1, W_ECALL, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, W_ECALL, 1'b0, 1'b1);
        idle(3, 1'b0);

        // Reset while an ebreak sits in the pre-register.
        step(1'b1, W_EBREAK, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1, 1'b0);
        rst_n = 1'b1;
        idle(3, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), rand_word(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
        end
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_event_monitor.md
Name: decode_event_monitor

Overview:
Parametrised instruction-decode monitor for simulation benches and on-chip debug. It sits on the instruction Wishbone return path (wb_rdt qualified by wb_en) and classifies each fetched word into control-flow and trap event classes. For each class it keeps a saturating counter and a registered event pulse. Events are pushed into a small FIFO with a valid/ready drain port, and overflow is flagged sticky.

Parameters:
PRE_REGISTER, 1, 1: instruction word registered on wb_en and classified next cycle; 0: classified in the wb_en cycle
CNT_W, 16, width of each per-class counter (2..32)
DEPTH, 4, event FIFO depth; power of two, 2..64
EV_MASK, 5'b11111, per-class enable: bit0 ebreak, bit1 jal, bit2 jalr, bit3 mret, bit4 ecall

Ports:
wb_clk  in  1  clock, all state on rising edge
wb_rst_n  in  1  asynchronous active-low reset
wb_rdt  in  30  instruction bits [31:2]
wb_en  in  1  wb_rdt valid this cycle
i_clr  in  1  synchronous clear of counters, overflow and FIFO
o_ebreak  out  1  one-cycle pulse, ebreak classified
o_jal_or_jalr  out  1  one-cycle pulse, jal or jalr classified
o_mret  out  1  one-cycle pulse, mret classified
o_cnt  out  5*CNT_W  counters; class k at [k*CNT_W +: CNT_W]
o_ev_valid  out  1  FIFO non-empty
o_ev_data  out  33  head entry {class[2:0], instr[31:2]}
i_ev_ready  in  1  pop head when o_ev_valid is high
o_ev_level  out  $clog2(DEPTH)+1  FIFO occupancy
o_ovf  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (wb_rst_n low, asynchronous): all counters 0, all pulses 0, FIFO empty (o_ev_valid 0, o_ev_level 0, o_ev_data 0), o_ovf 0, pre-register 0 and its valid 0.
- Classification on word w = wb_rdt. Exactly one class matches, or none.
  - class 0 ebreak: w == 30'h0004001C
  - class 1 jal: w[6:2] == 5'b11011
  - class 2 jalr: w[6:2] == 5'b11001 and w[14:12] == 0
  - class 3 mret: w == 30'h0C08001C
  - class 4 ecall: w == 30'h0000001C
  - A class with EV_MASK bit 0 is ignored entirely: no pulse, no count, no push.
- Latency, counted from the rising edge that samples wb_en=1:
  - PRE_REGISTER=1: pulses, counters and FIFO push update one edge later, i.e. visible 2 cycles after the wb_en cycle.
  - PRE_REGISTER=0: visible 1 cycle after the wb_en cycle.
  - Back-to-back wb_en is fully pipelined: one event per cycle.
- Pulses are high for exactly one cycle per event. o_jal_or_jalr fires for class 1 or class 2.
- Counters increment by 1 per event and saturate at 2^CNT_W-1; they never wrap.
- FIFO push/pop:
  - Push when an event is classified and the FIFO is not full, or when it is full and a pop occurs in the same cycle; that same-cycle push is accepted and occupancy stays DEPTH.
  - Pop when o_ev_valid & i_ev_ready.
  - Push and pop in the same cycle when not full: level unchanged.
  - Pop when empty: no effect.
  - Push when full with no pop: the event is dropped (its counter and pulse still update) and o_ovf is set.
  - o_ev_data shows the head entry; it is held while i_ev_ready is low.
  - Read and write pointers wrap modulo DEPTH.
- i_clr (synchronous): counters become 0, o_ovf 0, FIFO emptied; any event completing in the same cycle is discarded (clr wins). An event still in the pre-register stage is not affected and completes normally after the clr.
- Reset asserted mid-pipeline discards the in-flight event; nothing is emitted after release until a new wb_en.
- wb_rdt is don't-care when wb_en=0.

Test Plan:
- PRE_REGISTER=1: wb_en with wb_rdt=30'h0004001C -> o_ebreak pulses exactly 1 cycle, 2 cycles later; cnt[0]=1; o_ev_data={3'd0, 30'h0004001C}, o_ev_level=1.
- PRE_REGISTER=0: jal (0x0000006F>>2) then jalr (0x00008067>>2) back-to-back -> o_jal_or_jalr high 2 consecutive cycles, starting 1 cycle after the first; cnt[1]=1, cnt[2]=1; pops return class 1 then class 2.
- DEPTH=4, i_ev_ready=0, 6 mret words -> level=4, o_ovf=1, cnt[3]=6. Then pop one while pushing one in the same cycle -> level stays 4 and the new entry is at the tail.
- CNT_W=4: 17 ecall words -> cnt[4]=15 (saturated). i_clr -> cnt[4]=0, o_ovf=0, level=0.
- EV_MASK=5'b11110 with ebreak -> no pulse, cnt[0]=0, no push. Non-matching word (addi, 0x00100093>>2) -> no effect in any class.
- Assert wb_rst_n low 1 cycle after wb_en of an ebreak (PRE_REGISTER=1) -> no pulse ever, counters 0, FIFO empty after release.
